mem_eeprom: RTL and testbench
=============================

MEM_EEPROM -- requirements
Module: mem_eeprom

Interface
- REQ-001 clk  input  1  Single clock; all storage and output updates occur on its rising edge.
- REQ-002 reset_n  input  1  Asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- REQ-003 ce  input  1  Clock enable; when 0, the cycle performs no read and no write.
- REQ-004 ad  input  16  Bit address, 0..65535.
- REQ-005 wre  input  1  Write enable; qualified by ce.
- REQ-006 oce  input  1  Output register enable; when 0, dout holds its value.
- REQ-007 din  input  1  Write data bit.
- REQ-008 dout  output  1  Registered read data bit.

Function
- REQ-009 SHALL implement a 65536 x 1 single-port synchronous RAM, used as EEPROM backing store: 1024 blocks x 64 bits, ad = {block[9:0], bit[5:0]}.
- REQ-010 Write: on a rising edge with reset_n=1, ce=1 and wre=1, the location at ad SHALL take the value of din.
- REQ-011 Read latency SHALL be 1 cycle: on a rising edge with reset_n=1, ce=1 and oce=1, dout SHALL take the location at ad.
- REQ-012 Read-before-write: a cycle that writes and reads the same ad SHALL drive dout with the old content; the new value SHALL appear on the next read of that address.
- REQ-013 ce=0 SHALL block writes and SHALL leave dout unchanged, whatever the state of wre, oce and din.
- REQ-014 oce=0 with ce=1 SHALL still perform a write when wre=1, and SHALL leave dout unchanged.
- REQ-015 Address decode SHALL be exact over the full 16-bit range, with no aliasing.
  - ad=0xFFFF and ad=0x0000 SHALL be independent locations.
  - There is no wrap-around beyond 0xFFFF.
- REQ-016 Back-to-back operations SHALL be accepted every cycle; there is no busy or stall condition.

Reset
- REQ-017 While reset_n=0, dout SHALL be 0, asynchronously, and no write SHALL occur.
- REQ-018 Reset SHALL NOT alter memory contents.
  - A write coincident with reset assertion SHALL be discarded.
  - All other locations SHALL keep their values through reset.
- REQ-019 First edge after reset_n deasserts SHALL behave as a normal cycle.

Configuration
- REQ-020 Macro MEM_EEPROM_INIT_ONES_EN defines the power-up / configuration contents.
  - Defined: every location SHALL be 1, the erased-EEPROM state.
  - Undefined: every location SHALL be 0.
  - The macro SHALL have no other effect on behaviour or timing.

Structure
- REQ-021 A shared package mem_eeprom_pkg SHALL hold these constants: MEM_EEPROM_ADDR_W=16, MEM_EEPROM_BANK_ADDR_W=14, MEM_EEPROM_NUM_BANKS=4, MEM_EEPROM_BLOCK_BITS=64.
- REQ-022 Storage SHALL be split into 4 instances of one sub-module, mem_eeprom_bank, each 16384 x 1, so each maps to one block RAM.
  - Bank selection uses ad[15:14].
  - Write enable goes only to the selected bank.
- REQ-023 Bank read data SHALL be selected by the registered ad[15:14] into the dout register, preserving the 1-cycle latency of REQ-011.

Verification
- REQ-024 Write din=1 to 0x0000, 0x3FFF, 0x4000, 0xFFFF, then read each address -> 1 one cycle later; 0x0001 and 0x7FFF read back at their initial value.
- REQ-025 Write 1 to ad=0x1234, then in the next cycle write 0 to the same address with oce=1 -> dout=1 (old data); the following read gives 0.
- REQ-026 Write with ce=0, wre=1, din=1 to 0x0040 -> location unchanged and dout unchanged.
- REQ-027 Set oce=0, then read 0x0040 (content differs from the current dout) -> dout holds; raise oce -> new data one cycle later.
- REQ-028 Write 64 consecutive bits at block 5 (ad=0x0140..0x017F), then pulse reset_n low mid-sequence -> dout=0 immediately; previously written bits read back intact after reset.
- REQ-029 Build with and without MEM_EEPROM_INIT_ONES_EN, then read 0xABCD before any write -> 1 and 0 respectively.

Source files
------------

// File: rtl/mem_eeprom_pkg.sv
// mem_eeprom_pkg
// Shared constants and helpers for the 64K x 1 EEPROM backing store.
// Configuration macro: MEM_EEPROM_INIT_ONES_EN
//   defined   -> storage powers up all ones (erased EEPROM)
//   undefined -> storage powers up all zeros
package mem_eeprom_pkg;

  localparam int MEM_EEPROM_ADDR_W      = 16;
  localparam int MEM_EEPROM_BANK_ADDR_W = 14;
  localparam int MEM_EEPROM_NUM_BANKS   = 4;
  localparam int MEM_EEPROM_BLOCK_BITS  = 64;

  localparam int MEM_EEPROM_BANK_SEL_W  = MEM_EEPROM_ADDR_W - MEM_EEPROM_BANK_ADDR_W;
  localparam int MEM_EEPROM_BANK_DEPTH  = 1 << MEM_EEPROM_BANK_ADDR_W;

`ifdef MEM_EEPROM_INIT_ONES_EN
  localparam logic MEM_EEPROM_INIT_VAL = 1'b1;
`else
  localparam logic MEM_EEPROM_INIT_VAL = 1'b0;
`endif

  typedef logic [MEM_EEPROM_BANK_SEL_W-1:0]  bank_sel_t;
  typedef logic [MEM_EEPROM_BANK_ADDR_W-1:0] bank_addr_t;

  // Upper address bits pick the bank.
  function automatic bank_sel_t bank_of(input logic [MEM_EEPROM_ADDR_W-1:0] addr);
    return addr[MEM_EEPROM_ADDR_W-1:MEM_EEPROM_BANK_ADDR_W];
  endfunction

endpackage

// File: rtl/mem_eeprom_bank.sv
// mem_eeprom_bank
// One 16384 x 1 storage bank with a registered read port, shaped to map onto
// a single block RAM.
// Ports:
//   clk      - clock
//   reset_n  - async active-low reset (clears read register, blocks writes)
//   wr_en_i  - write strobe for this bank
//   rd_en_i  - read register enable
//   addr_i   - bank-local address
//   wdata_i  - write data bit
//   rdata_o  - registered read data bit
module mem_eeprom_bank
  import mem_eeprom_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en_i,
  input  logic       rd_en_i,
  input  bank_addr_t addr_i,
  input  logic       wdata_i,
  output logic       rdata_o
);

  // Power-up contents come from the package; reset never touches the array.
  logic mem_q [MEM_EEPROM_BANK_DEPTH] = '{default: MEM_EEPROM_INIT_VAL};
  logic rdata_q;

  // A write sampled while reset is low is dropped.
  always_ff @(posedge clk) begin
    if (wr_en_i && reset_n) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Non-blocking read of the array gives read-before-write on the same address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= 1'b0;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_eeprom.sv
// mem_eeprom
// 65536 x 1 single-port synchronous RAM used as EEPROM backing store
// (1024 blocks x 64 bits, ad = {block, bit}). Built from four 16K banks.
// Configuration macro: MEM_EEPROM_INIT_ONES_EN (power-up contents all ones).
// Ports:
//   clk     - clock
//   reset_n - async active-low reset; forces dout to 0, memory untouched
//   ce      - clock enable for both read and write
//   ad      - 16-bit bit address
//   wre     - write enable (qualified by ce)
//   oce     - output register enable (qualified by ce)
//   din     - write data bit
//   dout    - read data bit, one cycle latency
module mem_eeprom
  import mem_eeprom_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ce,
  input  logic [MEM_EEPROM_ADDR_W-1:0] ad,
  input  logic                         wre,
  input  logic                         oce,
  input  logic                         din,
  output logic                         dout
);

  bank_sel_t                       sel_d;
  bank_sel_t                       sel_q;
  logic [MEM_EEPROM_NUM_BANKS-1:0] bank_we;
  logic [MEM_EEPROM_NUM_BANKS-1:0] bank_rd;
  logic                            rd_en;

  assign sel_d = bank_of(ad);
  assign rd_en = ce && oce;

  // All banks read in parallel; only the addressed bank is written.
  for (genvar b = 0; b < MEM_EEPROM_NUM_BANKS; b++) begin : g_bank
    assign bank_we[b] = ce && wre && (sel_d == bank_sel_t'(b));

    mem_eeprom_bank u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en_i (bank_we[b]),
      .rd_en_i (rd_en),
      .addr_i  (ad[MEM_EEPROM_BANK_ADDR_W-1:0]),
      .wdata_i (din),
      .rdata_o (bank_rd[b])
    );
  end

  // Bank select is captured alongside the bank read registers so the output
  // mux follows the same address; it holds with them when oce is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q <= '0;
    end else if (rd_en) begin
      sel_q <= sel_d;
    end
  end

  // Every bank read register is 0 in reset, so dout is 0 whatever sel_q holds.
  assign dout = bank_rd[sel_q];

endmodule

// File: tb/tb_mem_eeprom.sv
// tb_mem_eeprom
// Directed self-checking bench for mem_eeprom.
// Honours MEM_EEPROM_INIT_ONES_EN for the expected power-up contents.
module tb_mem_eeprom;

`ifdef MEM_EEPROM_INIT_ONES_EN
  localparam logic INIT = 1'b1;
`else
  localparam logic INIT = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        ce;
  logic [15:0] ad;
  logic        wre;
  logic        oce;
  logic        din;
  logic        dout;

  int errors = 0;
  int checks = 0;

  mem_eeprom dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .ad      (ad),
    .wre     (wre),
    .oce     (oce),
    .din     (din),
    .dout    (dout)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs on the falling edge, then settle past the rising edge.
  task automatic applyStimulus(input logic c, input logic w, input logic o,
                               input logic [15:0] a, input logic d);
    @(negedge clk);
    ce  = c;
    wre = w;
    oce = o;
    ad  = a;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic expected);
    checks++;
    assert (dout === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: dout=%b expected=%b", tag, dout, expected);
    end
  endtask

  // Data pattern for the block-5 sweep
  function automatic logic pat(input int i);
    return ((i % 3) == 0) ^ ((i % 8) >= 5);
  endfunction

  initial begin
    reset_n = 1'b0;
    ce      = 1'b0;
    wre     = 1'b0;
    oce     = 1'b0;
    ad      = 16'h0000;
    din     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetDout", 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Power-up contents before any write
    applyStimulus(1, 0, 1, 16'hABCD, 0);
    checkOutput("initABCD", INIT);

    // Writes at bank edges, then readback
    applyStimulus(1, 1, 0, 16'h0000, 1);
    applyStimulus(1, 1, 0, 16'h3FFF, 1);
    applyStimulus(1, 1, 0, 16'h4000, 1);
    applyStimulus(1, 1, 0, 16'hFFFF, 1);
    checkOutput("oceLowHoldsAfterWrites", INIT);
    applyStimulus(1, 0, 1, 16'h0000, 0);
    checkOutput("rd0000", 1'b1);
    applyStimulus(1, 0, 1, 16'h3FFF, 0);
    checkOutput("rd3FFF", 1'b1);
    applyStimulus(1, 0, 1, 16'h4000, 0);
    checkOutput("rd4000", 1'b1);
    applyStimulus(1, 0, 1, 16'hFFFF, 0);
    checkOutput("rdFFFF", 1'b1);
    applyStimulus(1, 0, 1, 16'h0001, 0);
    checkOutput("rd0001", INIT);
    applyStimulus(1, 0, 1, 16'h7FFF, 0);
    checkOutput("rd7FFF", INIT);

    // 0x0000 and 0xFFFF must be independent
    applyStimulus(1, 1, 0, 16'h0000, 0);
    applyStimulus(1, 0, 1, 16'hFFFF, 0);
    checkOutput("noAliasFFFF", 1'b1);
    applyStimulus(1, 0, 1, 16'h0000, 0);
    checkOutput("noAlias0000", 1'b0);

    // Read-before-write on 0x1234
    applyStimulus(1, 1, 1, 16'h1234, 1);
    checkOutput("rbw1234First", INIT);
    applyStimulus(1, 1, 1, 16'h1234, 0);
    checkOutput("rbw1234Old", 1'b1);
    applyStimulus(1, 0, 1, 16'h1234, 0);
    checkOutput("rbw1234New", 1'b0);

    // ce=0 blocks write and read: set 0x0040 to 0, put a 1 on dout first
    applyStimulus(1, 1, 0, 16'h0040, 0);
    applyStimulus(1, 0, 1, 16'h4000, 0);
    checkOutput("preCeDout", 1'b1);
    applyStimulus(0, 1, 1, 16'h0040, 1);
    checkOutput("ceLowHold", 1'b1);
    applyStimulus(1, 0, 1, 16'h0040, 0);
    checkOutput("ceLowNoWrite", 1'b0);

    // oce=0 holds dout but still writes
    applyStimulus(1, 0, 1, 16'h4000, 0);
    checkOutput("preOceDout", 1'b1);
    applyStimulus(1, 0, 0, 16'h0040, 0);
    checkOutput("oceLowReadHold", 1'b1);
    applyStimulus(1, 1, 0, 16'h0042, ~INIT);
    checkOutput("oceLowWriteHold", 1'b1);
    applyStimulus(1, 0, 1, 16'h0040, 0);
    checkOutput("oceHighRead0040", 1'b0);
    applyStimulus(1, 0, 1, 16'h0042, 0);
    checkOutput("oceLowWrote0042", ~INIT);

    // Block 5 sweep with a reset pulse in the middle
    applyStimulus(1, 0, 1, 16'h4000, 0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 1, 0, 16'h0140 + 16'(i), pat(i));
    end
    checkOutput("preResetDout", 1'b1);

    // Reset with a conflicting write to 0x0140 held across an edge
    @(negedge clk);
    reset_n = 1'b0;
    ce      = 1'b1;
    wre     = 1'b1;
    oce     = 1'b1;
    ad      = 16'h0140;
    din     = ~pat(0);
    #1;
    checkOutput("asyncResetDout", 1'b0);
    @(posedge clk);
    #1;
    checkOutput("resetHoldDout", 1'b0);

    // First edge after release is a normal write
    @(negedge clk);
    reset_n = 1'b1;
    ce      = 1'b1;
    wre     = 1'b1;
    oce     = 1'b0;
    ad      = 16'h0140 + 16'd40;
    din     = pat(40);
    @(posedge clk);
    #1;
    checkOutput("postResetOceLow", 1'b0);
    for (int i = 41; i < 64; i++) begin
      applyStimulus(1, 1, 0, 16'h0140 + 16'(i), pat(i));
    end

    // Readback of the whole block
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1, 0, 1, 16'h0140 + 16'(i), 0);
      checkOutput($sformatf("blk5Bit%0d", i), pat(i));
    end

    // Neighbouring block untouched by the sweep
    applyStimulus(1, 0, 1, 16'h0180, 0);
    checkOutput("blk6Untouched", INIT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
